// File: rtl/pipe_pkg.sv
// Shared pipeline constants: ALU state codes, RV32I opcode/funct fields, operand-2 source select.
// ID_EX_MULSLT_EN enables the mul/slt decode; undefined, both encodings are illegal.
package pipe_pkg;

    localparam logic [3:0] NOP_STATE = 4'b0000;

    localparam logic [3:0] ST_ADD = 4'b0000;
    localparam logic [3:0] ST_SUB = 4'b0001;
    localparam logic [3:0] ST_SLL = 4'b0010;
    localparam logic [3:0] ST_XOR = 4'b0011;
    localparam logic [3:0] ST_SRL = 4'b0100;
    localparam logic [3:0] ST_OR  = 4'b0101;
    localparam logic [3:0] ST_AND = 4'b0110;
    localparam logic [3:0] ST_BEQ = 4'b1001;
    localparam logic [3:0] ST_BLT = 4'b1010;
    localparam logic [3:0] ST_JAL = 4'b1011;
    localparam logic [3:0] ST_MUL = 4'b1100;
    localparam logic [3:0] ST_SLT = 4'b1110;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_SRL = 3'b101;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BLT = 3'b100;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;
    localparam logic [6:0] F7_MUL  = 7'b0000001;

`ifdef ID_EX_MULSLT_EN
    localparam bit MULSLT_EN = 1'b1;
`else
    localparam bit MULSLT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        SRC_RS2   = 2'd0,
        SRC_IMM_I = 2'd1,
        SRC_IMM_S = 2'd2,
        SRC_ZERO  = 2'd3
    } op2_src_t;

    // States whose EX cycle can redirect the PC when the ALU flag is set.
    function automatic logic is_ctrl_state(input logic [3:0] st);
        return (st == ST_BEQ) || (st == ST_BLT) || (st == ST_JAL);
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction; every form is sign-extended to XLEN.
module imm_gen #(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [XLEN-1:0] imm_i,
    output logic [XLEN-1:0] imm_s,
    output logic [XLEN-1:0] imm_b,
    output logic [XLEN-1:0] imm_j
);

    assign imm_i = {{(XLEN-12){inst[31]}}, inst[31:20]};
    assign imm_s = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
    // Branch and jump offsets are halfword-aligned, so bit 0 is always zero.
    assign imm_b = {{(XLEN-13){inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

endmodule

// File: rtl/id_ex_stage.sv
// Decode, operand forwarding, load-use stall and branch flush feeding the ID/EX register.
// Build with ID_EX_MULSLT_EN defined to decode mul and slt.
module id_ex_stage #(
    parameter int         XLEN      = 32,
    parameter logic [3:0] NOP_STATE = 4'b0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     inst_i,
    input  logic [31:0]     inst_addr_i,
    input  logic            id_valid_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [XLEN-1:0] ex_result_i,
    input  logic            ex_zero_i,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_wen_i,
    input  logic [XLEN-1:0] mem_data_i,
    output logic            stall_o,
    output logic [3:0]      state_o,
    output logic [XLEN-1:0] operand1_o,
    output logic [XLEN-1:0] operand2_o,
    output logic [31:0]     inst_addr_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] store_data_o,
    output logic [4:0]      rd_o,
    output logic            wen_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic            valid_o
);
    import pipe_pkg::*;

    logic [6:0] opcode, f7;
    logic [2:0] f3;
    logic [4:0] rd, rs1, rs2;
    assign opcode = inst_i[6:0];
    assign rd     = inst_i[11:7];
    assign f3     = inst_i[14:12];
    assign rs1    = inst_i[19:15];
    assign rs2    = inst_i[24:20];
    assign f7     = inst_i[31:25];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;
    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .inst  (inst_i),
        .imm_i (imm_i),
        .imm_s (imm_s),
        .imm_b (imm_b),
        .imm_j (imm_j)
    );

    logic       dec_legal, dec_use_rs1, dec_use_rs2, dec_wen;
    logic       dec_load, dec_store, dec_branch, dec_jal, dec_shift;
    logic [3:0] dec_state;
    op2_src_t   dec_op2_src;

    always_comb begin
        dec_legal   = 1'b0;
        dec_state   = NOP_STATE;
        dec_use_rs1 = 1'b0;
        dec_use_rs2 = 1'b0;
        dec_wen     = 1'b0;
        dec_load    = 1'b0;
        dec_store   = 1'b0;
        dec_branch  = 1'b0;
        dec_jal     = 1'b0;
        dec_shift   = 1'b0;
        dec_op2_src = SRC_RS2;
        case (opcode)
            OP_R: begin
                dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1;
                dec_wen     = 1'b1;
                case ({f7, f3})
                    {F7_BASE, F3_ADD}: begin dec_state = ST_ADD; dec_legal = 1'b1; end
                    {F7_SUB,  F3_ADD}: begin dec_state = ST_SUB; dec_legal = 1'b1; end
                    {F7_BASE, F3_SLL}: begin dec_state = ST_SLL; dec_legal = 1'b1; dec_shift = 1'b1; end
                    {F7_BASE, F3_XOR}: begin dec_state = ST_XOR; dec_legal = 1'b1; end
                    {F7_BASE, F3_SRL}: begin dec_state = ST_SRL; dec_legal = 1'b1; dec_shift = 1'b1; end
                    {F7_BASE, F3_OR }: begin dec_state = ST_OR;  dec_legal = 1'b1; end
                    {F7_BASE, F3_AND}: begin dec_state = ST_AND; dec_legal = 1'b1; end
                    {F7_MUL,  F3_ADD}: begin dec_state = ST_MUL; dec_legal = MULSLT_EN; end
                    {F7_BASE, F3_SLT}: begin dec_state = ST_SLT; dec_legal = MULSLT_EN; end
                    default: ;
                endcase
            end
            OP_I: if (f3 == F3_ADD) begin
                dec_legal = 1'b1; dec_state = ST_ADD; dec_use_rs1 = 1'b1;
                dec_wen = 1'b1; dec_op2_src = SRC_IMM_I;
            end
            OP_LOAD: if (f3 == F3_LW) begin
                dec_legal = 1'b1; dec_state = ST_ADD; dec_use_rs1 = 1'b1;
                dec_wen = 1'b1; dec_load = 1'b1; dec_op2_src = SRC_IMM_I;
            end
            OP_STORE: if (f3 == F3_SW) begin
                dec_legal = 1'b1; dec_state = ST_ADD; dec_use_rs1 = 1'b1;
                dec_use_rs2 = 1'b1; dec_store = 1'b1; dec_op2_src = SRC_IMM_S;
            end
            OP_BRANCH: if (f3 == F3_BEQ || f3 == F3_BLT) begin
                dec_legal = 1'b1; dec_state = (f3 == F3_BEQ) ? ST_BEQ : ST_BLT;
                dec_use_rs1 = 1'b1; dec_use_rs2 = 1'b1; dec_branch = 1'b1;
            end
            OP_JAL: begin
                dec_legal = 1'b1; dec_state = ST_JAL; dec_wen = 1'b1;
                dec_jal = 1'b1; dec_op2_src = SRC_ZERO;
            end
            default: ;
        endcase
    end

    // A load in EX has no result yet, so only non-load producers forward from EX.
    logic            ex_fwd_ok;
    logic [XLEN-1:0] fwd1, fwd2;
    assign ex_fwd_ok = valid_o && wen_o && !mem_read_o;

    always_comb begin
        if (rs1 != 5'd0 && ex_fwd_ok && rd_o == rs1)          fwd1 = ex_result_i;
        else if (rs1 != 5'd0 && mem_wen_i && mem_rd_i == rs1) fwd1 = mem_data_i;
        else                                                  fwd1 = rs1_data_i;
        if (rs2 != 5'd0 && ex_fwd_ok && rd_o == rs2)          fwd2 = ex_result_i;
        else if (rs2 != 5'd0 && mem_wen_i && mem_rd_i == rs2) fwd2 = mem_data_i;
        else                                                  fwd2 = rs2_data_i;
    end

    logic load_use, flush, issue;
    assign load_use = valid_o && mem_read_o && rd_o != 5'd0 && id_valid_i && dec_legal &&
                      ((dec_use_rs1 && rs1 == rd_o) || (dec_use_rs2 && rs2 == rd_o));
    assign flush    = valid_o && is_ctrl_state(state_o) && ex_zero_i;
    assign stall_o  = load_use && !flush;
    assign issue    = id_valid_i && dec_legal && !flush && !load_use;

    logic [XLEN-1:0] op2_d;
    always_comb begin
        case (dec_op2_src)
            SRC_RS2:   op2_d = dec_shift ? {{(XLEN-5){1'b0}}, fwd2[4:0]} : fwd2;
            SRC_IMM_I: op2_d = imm_i;
            SRC_IMM_S: op2_d = imm_s;
            default:   op2_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || !issue) begin
            state_o      <= NOP_STATE;
            operand1_o   <= '0;
            operand2_o   <= '0;
            inst_addr_o  <= '0;
            imm_o        <= '0;
            store_data_o <= '0;
            rd_o         <= '0;
            wen_o        <= 1'b0;
            mem_read_o   <= 1'b0;
            mem_write_o  <= 1'b0;
            valid_o      <= 1'b0;
        end else begin
            state_o      <= dec_state;
            operand1_o   <= dec_jal ? '0 : fwd1;
            operand2_o   <= op2_d;
            inst_addr_o  <= inst_addr_i;
            imm_o        <= dec_branch ? imm_b : (dec_jal ? imm_j : '0);
            store_data_o <= dec_store ? fwd2 : '0;
            rd_o         <= dec_wen ? rd : 5'd0;
            wen_o        <= dec_wen;
            mem_read_o   <= dec_load;
            mem_write_o  <= dec_store;
            valid_o      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage: table of {inputs, expected} plus reset/stall sequences.
module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i, inst_addr_i;
    logic        id_valid_i;
    logic [31:0] rs1_data_i, rs2_data_i, ex_result_i, mem_data_i;
    logic        ex_zero_i, mem_wen_i;
    logic [4:0]  mem_rd_i;
    logic        stall_o;
    logic [3:0]  state_o;
    logic [31:0] operand1_o, operand2_o, inst_addr_o, imm_o, store_data_o;
    logic [4:0]  rd_o;
    logic        wen_o, mem_read_o, mem_write_o, valid_o;

    int n_cmp = 0;
    int n_bad = 0;

    id_ex_stage dut (
        .clk(clk), .rst(rst), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .id_valid_i(id_valid_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i),
        .ex_result_i(ex_result_i), .ex_zero_i(ex_zero_i), .mem_rd_i(mem_rd_i),
        .mem_wen_i(mem_wen_i), .mem_data_i(mem_data_i), .stall_o(stall_o),
        .state_o(state_o), .operand1_o(operand1_o), .operand2_o(operand2_o),
        .inst_addr_o(inst_addr_o), .imm_o(imm_o), .store_data_o(store_data_o),
        .rd_o(rd_o), .wen_o(wen_o), .mem_read_o(mem_read_o),
        .mem_write_o(mem_write_o), .valid_o(valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // e_ctl packs the expected {wen, mem_read, mem_write, valid}.
    typedef struct {
        logic [31:0] inst, pc;
        logic        idv;
        logic [31:0] rs1, rs2, exr;
        logic        exz;
        logic [4:0]  mrd;
        logic        mwen;
        logic [31:0] mdata;
        logic        e_stall;
        logic [3:0]  e_state;
        logic [31:0] e_op1, e_op2, e_imm, e_sd;
        logic [4:0]  e_rd;
        logic [3:0]  e_ctl;
        logic [31:0] e_addr;
    } vec_t;

    function automatic vec_t mk(
        input logic [31:0] inst, input logic [31:0] pc, input logic idv,
        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] exr, input logic exz,
        input logic [4:0] mrd, input logic mwen, input logic [31:0] mdata,
        input logic e_stall, input logic [3:0] e_state, input logic [31:0] e_op1,
        input logic [31:0] e_op2, input logic [31:0] e_imm, input logic [31:0] e_sd,
        input logic [4:0] e_rd, input logic [3:0] e_ctl, input logic [31:0] e_addr);
        vec_t v;
        v.inst = inst; v.pc = pc; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.exr = exr;
        v.exz = exz; v.mrd = mrd; v.mwen = mwen; v.mdata = mdata; v.e_stall = e_stall;
        v.e_state = e_state; v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_imm = e_imm;
        v.e_sd = e_sd; v.e_rd = e_rd; v.e_ctl = e_ctl; v.e_addr = e_addr;
        return v;
    endfunction

    // Inputs only; expectations all describe a bubble.
    function automatic vec_t mk_bub(
        input logic [31:0] inst, input logic [31:0] pc, input logic idv,
        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] exr, input logic exz,
        input logic e_stall);
        return mk(inst, pc, idv, rs1, rs2, exr, exz, 5'd0, 1'b0, 32'h0,
                  e_stall, 4'b0000, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 4'b0000, 32'h0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        inst_i = v.inst; inst_addr_i = v.pc; id_valid_i = v.idv;
        rs1_data_i = v.rs1; rs2_data_i = v.rs2; ex_result_i = v.exr; ex_zero_i = v.exz;
        mem_rd_i = v.mrd; mem_wen_i = v.mwen; mem_data_i = v.mdata;
    endtask

    task automatic check_regs(input string tag, input vec_t v);
        check({tag, ".state"}, {28'h0, state_o}, {28'h0, v.e_state});
        check({tag, ".op1"}, operand1_o, v.e_op1);
        check({tag, ".op2"}, operand2_o, v.e_op2);
        check({tag, ".imm"}, imm_o, v.e_imm);
        check({tag, ".store_data"}, store_data_o, v.e_sd);
        check({tag, ".rd"}, {27'h0, rd_o}, {27'h0, v.e_rd});
        check({tag, ".ctl"}, {28'h0, wen_o, mem_read_o, mem_write_o, valid_o}, {28'h0, v.e_ctl});
        check({tag, ".addr"}, inst_addr_o, v.e_addr);
    endtask

    localparam logic [31:0] I_ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] I_SUB_X2     = 32'h40108133;
    localparam logic [31:0] I_LW_X3      = 32'h00002183;
    localparam logic [31:0] I_ADD_X4     = 32'h00318233;
    localparam logic [31:0] I_SLL_X7     = 32'h002093B3;
    localparam logic [31:0] I_BEQ_8      = 32'h00000463;
    localparam logic [31:0] I_LW_X5_X1   = 32'h0000A283;
    localparam logic [31:0] I_LW_X1_X1   = 32'h0000A083;
    localparam logic [31:0] I_JAL_M4     = 32'hFFDFF0EF;
    localparam logic [31:0] I_LW_X31     = 32'h00402F83;
    localparam logic [31:0] I_ADDI_X6_M1 = 32'hFFF10313;
    localparam logic [31:0] I_AND_X8     = 32'h00537433;
    localparam logic [31:0] I_SW_M8      = 32'hFE812C23;
    localparam logic [31:0] I_ILLEGAL    = 32'h0000007F;
    localparam logic [31:0] I_MUL_X6     = 32'h02208333;
    localparam logic [31:0] I_BLT_M16    = 32'hFE20C8E3;

    vec_t vecs[$];
    vec_t v;

    initial begin
        vecs.push_back(mk(I_ADDI_X1_5, 32'h00, 1, 0, 0, 0, 0, 0, 0, 0,
                          0, 4'h0, 32'h0, 32'h5, 32'h0, 32'h0, 5'd1, 4'b1001, 32'h00));
        vecs.push_back(mk(I_SUB_X2, 32'h04, 1, 0, 0, 5, 0, 0, 0, 0,
                          0, 4'h1, 32'h5, 32'h5, 32'h0, 32'h0, 5'd2, 4'b1001, 32'h04));
        vecs.push_back(mk(I_LW_X3, 32'h08, 1, 0, 0, 32'h77, 0, 0, 0, 0,
                          0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd3, 4'b1101, 32'h08));
        vecs.push_back(mk_bub(I_ADD_X4, 32'h0C, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(I_ADD_X4, 32'h0C, 1, 0, 0, 32'h1111, 0, 5'd3, 1, 32'hDEADBEEF,
                          0, 4'h0, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 32'h0, 5'd4, 4'b1001, 32'h0C));
        vecs.push_back(mk(I_SLL_X7, 32'h3C, 1, 32'h10, 32'hFFFFFF23, 0, 0, 0, 0, 0,
                          0, 4'h2, 32'h10, 32'h3, 32'h0, 32'h0, 5'd7, 4'b1001, 32'h3C));
        vecs.push_back(mk(I_BEQ_8, 32'h10, 1, 0, 0, 32'h99, 0, 0, 0, 0,
                          0, 4'h9, 32'h0, 32'h0, 32'h8, 32'h0, 5'd0, 4'b0001, 32'h10));
        vecs.push_back(mk_bub(I_LW_X5_X1, 32'h14, 1, 32'h100, 0, 0, 1, 0));
        vecs.push_back(mk(I_LW_X1_X1, 32'h18, 1, 32'h100, 0, 0, 0, 0, 0, 0,
                          0, 4'h0, 32'h100, 32'h0, 32'h0, 32'h0, 5'd1, 4'b1101, 32'h18));
        vecs.push_back(mk(I_JAL_M4, 32'h20, 1, 0, 0, 0, 0, 0, 0, 0,
                          0, 4'hB, 32'h0, 32'h0, 32'hFFFFFFFC, 32'h0, 5'd1, 4'b1001, 32'h20));
        vecs.push_back(mk(I_LW_X31, 32'h24, 1, 0, 0, 0, 0, 0, 0, 0,
                          0, 4'h0, 32'h0, 32'h4, 32'h0, 32'h0, 5'd31, 4'b1101, 32'h24));
        vecs.push_back(mk(I_ADDI_X6_M1, 32'h28, 1, 7, 0, 0, 0, 0, 0, 0,
                          0, 4'h0, 32'h7, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd6, 4'b1001, 32'h28));
        vecs.push_back(mk(I_AND_X8, 32'h2C, 1, 32'h11, 32'h55, 32'hAA, 0, 5'd6, 1, 32'hBB,
                          0, 4'h6, 32'hAA, 32'h55, 32'h0, 32'h0, 5'd8, 4'b1001, 32'h2C));
        vecs.push_back(mk(I_SW_M8, 32'h30, 1, 32'h200, 32'h4444, 32'h1234, 0, 0, 0, 0,
                          0, 4'h0, 32'h200, 32'hFFFFFFF8, 32'h0, 32'h1234, 5'd0, 4'b0011, 32'h30));
        vecs.push_back(mk_bub(I_ADDI_X1_5, 32'h34, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk_bub(I_ILLEGAL, 32'h38, 1, 0, 0, 0, 0, 0));
`ifdef ID_EX_MULSLT_EN
        vecs.push_back(mk(I_MUL_X6, 32'h3C, 1, 3, 4, 0, 0, 0, 0, 0,
                          0, 4'hC, 32'h3, 32'h4, 32'h0, 32'h0, 5'd6, 4'b1001, 32'h3C));
`else
        vecs.push_back(mk_bub(I_MUL_X6, 32'h3C, 1, 3, 4, 0, 0, 0));
`endif
        vecs.push_back(mk(I_BLT_M16, 32'h40, 1, 32'hFFFFFFFB, 3, 0, 0, 0, 0, 0,
                          0, 4'hA, 32'hFFFFFFFB, 32'h3, 32'hFFFFFFF0, 32'h0, 5'd0, 4'b0001, 32'h40));
        vecs.push_back(mk_bub(I_ADDI_X1_5, 32'h44, 1, 0, 0, 0, 1, 0));
        vecs.push_back(mk(I_ADDI_X1_5, 32'h48, 1, 0, 0, 0, 1, 0, 0, 0,
                          0, 4'h0, 32'h0, 32'h5, 32'h0, 32'h0, 5'd1, 4'b1001, 32'h48));
        vecs.push_back(mk(I_SUB_X2, 32'h4C, 1, 0, 0, 5, 1, 0, 0, 0,
                          0, 4'h1, 32'h5, 32'h5, 32'h0, 32'h0, 5'd2, 4'b1001, 32'h4C));

        // Reset held two cycles with a valid addi on the input.
        rst = 1'b1;
        drive(mk_bub(I_ADDI_X1_5, 32'h0, 1, 0, 0, 0, 0, 0));
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check($sformatf("reset%0d", c), {31'h0, stall_o}, 32'h0);
            check_regs($sformatf("reset%0d", c), mk_bub(I_ADDI_X1_5, 32'h0, 1, 0, 0, 0, 0, 0));
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d.stall", i), {31'h0, stall_o}, {31'h0, vecs[i].e_stall});
            @(posedge clk); #1;
            check_regs($sformatf("v%0d", i), vecs[i]);
        end

        // Reset asserted while a load-use stall is active.
        @(negedge clk);
        drive(mk_bub(I_LW_X3, 32'h50, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        check("rst_stall.lw.ctl", {28'h0, wen_o, mem_read_o, mem_write_o, valid_o}, 32'hD);
        @(negedge clk);
        v = mk(I_ADD_X4, 32'h54, 1, 9, 9, 0, 0, 0, 0, 0,
               0, 4'h0, 32'h9, 32'h9, 32'h0, 32'h0, 5'd4, 4'b1001, 32'h54);
        drive(v);
        #1;
        check("rst_stall.stall_before", {31'h0, stall_o}, 32'h1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_regs("rst_stall.bubble", mk_bub(I_ADD_X4, 32'h54, 1, 9, 9, 0, 0, 0));
        check("rst_stall.stall_after", {31'h0, stall_o}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall.stall_release", {31'h0, stall_o}, 32'h0);
        @(posedge clk); #1;
        check_regs("rst_stall.issue", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
